arashi_mem_mc: RTL and testbench

- Multi-channel capture buffer. Successor of the single-channel cache-to-memory sink.
- NUM_CH producers (cache slices) compete for one write port through a round-robin arbiter.
- Accepted words are stored, tagged with their source channel, in a circular buffer of depth 2**MEM_WIDTH.
- A read port drains entries in order with 1-cycle latency, and reports occupancy, full/empty and a sticky underflow error.

---
 rtl/arashi_mem_pkg.sv | 18 +
 rtl/arashi_rr_arb.sv | 39 +++
 rtl/arashi_mem_mc.sv | 117 +++++++++++
 tb/tb_arashi_mem_mc.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arashi_mem_pkg.sv
// arashi_mem shared definitions.
// Default sizes and small elaboration helpers.
package arashi_mem_pkg;

    localparam int ARASHI_DATA_WIDTH = 32;
    localparam int ARASHI_MEM_WIDTH  = 10;
    localparam int ARASHI_NUM_CH     = 4;

    // A one-wire tag or index still needs one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/arashi_rr_arb.sv
// Combinational round-robin arbiter.
// Searches from ptr upward, wrapping at N.
module arashi_rr_arb
    import arashi_mem_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = clog2_min1(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         en,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx
);

    logic         hit;
    int           c;
    logic [W-1:0] k;

    // First requester at or after ptr wins; en gates the grant.
    always_comb begin
        hit     = 1'b0;
        gnt     = '0;
        gnt_idx = '0;
        c       = 0;
        k       = '0;
        for (int i = 0; i < N; i++) begin
            c = int'(ptr) + i;
            if (c >= N) c = c - N;
            k = W'(c);
            if (!hit && req[k]) begin
                hit     = 1'b1;
                gnt_idx = k;
                gnt[k]  = en;
            end
        end
    end

endmodule

// File: rtl/arashi_mem_mc.sv
// Multi-channel capture buffer.
// Round-robin write arbitration into a tagged circular buffer.
module arashi_mem_mc
    import arashi_mem_pkg::*;
#(
    parameter  int DATA_WIDTH = ARASHI_DATA_WIDTH,
    parameter  int MEM_WIDTH  = ARASHI_MEM_WIDTH,
    parameter  int NUM_CH     = ARASHI_NUM_CH,
    localparam int CH_WIDTH   = clog2_min1(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NUM_CH-1:0]            wr_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] wr_data,
    output logic [NUM_CH-1:0]            wr_ready,
    input  logic                         rd_req,
    output logic                         rd_valid,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic [CH_WIDTH-1:0]          rd_ch,
    output logic [MEM_WIDTH:0]           count,
    output logic                         full,
    output logic                         empty,
    output logic                         underflow,
    input  logic                         clr_err
);

    localparam int DEPTH = 1 << MEM_WIDTH;
    localparam int PW    = MEM_WIDTH + 1;
    localparam int EW    = CH_WIDTH + DATA_WIDTH;

    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [CH_WIDTH-1:0]   rr_ptr;
    logic [EW-1:0]         mem [DEPTH];
    logic [NUM_CH-1:0]     gnt;
    logic [CH_WIDTH-1:0]   gnt_idx;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wr_en;
    logic                  rd_en;

    assign full  = (wptr[MEM_WIDTH] != rptr[MEM_WIDTH]) &&
                   (wptr[MEM_WIDTH-1:0] == rptr[MEM_WIDTH-1:0]);
    assign empty = (wptr == rptr);
    assign count = wptr - rptr;

    arashi_rr_arb #(
        .N (NUM_CH)
    ) u_arb (
        .req     (wr_valid),
        .ptr     (rr_ptr),
        .en      (!full),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign wr_ready = gnt;
    assign wr_en    = |gnt;
    assign rd_en    = rd_req && !empty;

    // Select the granted channel's data word.
    always_comb begin
        wdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_idx == CH_WIDTH'(i))
                wdata = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Storage write; left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wptr[MEM_WIDTH-1:0]] <= {gnt_idx, wdata};
    end

    // Pointers and the rotating arbitration start point.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr   <= '0;
            rptr   <= '0;
            rr_ptr <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + PW'(1);
                if (gnt_idx == CH_WIDTH'(NUM_CH - 1))
                    rr_ptr <= '0;
                else
                    rr_ptr <= gnt_idx + CH_WIDTH'(1);
            end
            if (rd_en)
                rptr <= rptr + PW'(1);
        end
    end

    // Registered read port; data holds when nothing is popped.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_ch    <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                {rd_ch, rd_data} <= mem[rptr[MEM_WIDTH-1:0]];
        end
    end

    // Sticky underflow flag; a new event beats a clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            underflow <= 1'b0;
        else if (rd_req && empty)
            underflow <= 1'b1;
        else if (clr_err)
            underflow <= 1'b0;
    end

endmodule

// File: tb/tb_arashi_mem_mc.sv
// Directed bench for arashi_mem_mc.
// Depth-8 instance so full and wrap are reachable quickly.
module tb_arashi_mem_mc;

    localparam int DW  = 32;
    localparam int MW  = 3;
    localparam int NCH = 4;
    localparam int CW  = 2;

    logic              clk;
    logic              rstn;
    logic [NCH-1:0]    wr_valid;
    logic [NCH*DW-1:0] wr_data;
    logic [NCH-1:0]    wr_ready;
    logic              rd_req;
    logic              rd_valid;
    logic [DW-1:0]     rd_data;
    logic [CW-1:0]     rd_ch;
    logic [MW:0]       count;
    logic              full;
    logic              empty;
    logic              underflow;
    logic              clr_err;

    int vecs;
    int errs;

    arashi_mem_mc #(
        .DATA_WIDTH (DW),
        .MEM_WIDTH  (MW),
        .NUM_CH     (NCH)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rd_req    (rd_req),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_ch     (rd_ch),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .underflow (underflow),
        .clr_err   (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int ch, input logic [DW-1:0] v);
        wr_data[ch*DW +: DW] = v;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        wr_valid = '0;
        wr_data = '0;
        rd_req = 1'b0;
        clr_err = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
        vecs++;
        if (empty !== 1'b1 || full !== 1'b0 || count !== 4'd0) begin
            errs++;
            $display("FAIL reset_flags: empty=%b full=%b count=%0d want 1 0 0",
                     empty, full, count);
        end
        vecs++;
        if (rd_valid !== 1'b0 || rd_data !== 32'd0 || rd_ch !== 2'd0 || underflow !== 1'b0) begin
            errs++;
            $display("FAIL reset_rd: v=%b d=%h ch=%0d uf=%b want 0 0 0 0",
                     rd_valid, rd_data, rd_ch, underflow);
        end
    endtask

    task automatic test_single();
        wr_valid = 4'b0100;
        set_data(2, 32'hA5A5_0001);
        #1;
        vecs++;
        if (wr_ready !== 4'b0100) begin
            errs++;
            $display("FAIL single_grant: got %b want 0100", wr_ready);
        end
        tick();
        wr_valid = '0;
        vecs++;
        if (count !== 4'd1 || empty !== 1'b0) begin
            errs++;
            $display("FAIL single_count1: count=%0d empty=%b want 1 0", count, empty);
        end
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        vecs++;
        if (rd_valid !== 1'b1 || rd_data !== 32'hA5A5_0001 || rd_ch !== 2'd2) begin
            errs++;
            $display("FAIL single_read: v=%b d=%h ch=%0d want 1 a5a50001 2",
                     rd_valid, rd_data, rd_ch);
        end
        vecs++;
        if (count !== 4'd0 || empty !== 1'b1) begin
            errs++;
            $display("FAIL single_count0: count=%0d empty=%b want 0 1", count, empty);
        end
        tick();
        vecs++;
        if (rd_valid !== 1'b0 || rd_data !== 32'hA5A5_0001) begin
            errs++;
            $display("FAIL single_hold: v=%b d=%h want 0 a5a50001", rd_valid, rd_data);
        end
    endtask

    task automatic test_async_reset();
        wr_valid = 4'b0001;
        set_data(0, 32'h0000_00AA);
        tick();
        tick();
        tick();
        wr_valid = '0;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        vecs++;
        if (count !== 4'd2 || rd_valid !== 1'b1) begin
            errs++;
            $display("FAIL pre_reset: count=%0d v=%b want 2 1", count, rd_valid);
        end
        rstn = 1'b0;
        #1;
        vecs++;
        if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 ||
            rd_valid !== 1'b0 || rd_data !== 32'd0 || rd_ch !== 2'd0) begin
            errs++;
            $display("FAIL async_reset: count=%0d e=%b f=%b v=%b d=%h ch=%0d want 0 1 0 0 0 0",
                     count, empty, full, rd_valid, rd_data, rd_ch);
        end
        #2;
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_rr_and_full();
        logic [NCH-1:0] exp_g;
        logic [CW-1:0]  exp_ch;
        wr_valid = 4'hF;
        for (int i = 0; i < NCH; i++) set_data(i, 32'h100 + i);
        for (int k = 0; k < 8; k++) begin
            exp_g = 4'b0001 << (k % 4);
            #1;
            vecs++;
            if (wr_ready !== exp_g) begin
                errs++;
                $display("FAIL rr_grant[%0d]: got %b want %b", k, wr_ready, exp_g);
            end
            tick();
        end
        vecs++;
        if (full !== 1'b1 || count !== 4'd8 || wr_ready !== 4'b0000) begin
            errs++;
            $display("FAIL full_state: f=%b count=%0d rdy=%b want 1 8 0000",
                     full, count, wr_ready);
        end
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        vecs++;
        if (count !== 4'd7 || rd_valid !== 1'b1 || rd_ch !== 2'd0 || rd_data !== 32'h100) begin
            errs++;
            $display("FAIL full_rw: count=%0d v=%b ch=%0d d=%h want 7 1 0 100",
                     count, rd_valid, rd_ch, rd_data);
        end
        #1;
        vecs++;
        if (wr_ready !== 4'b0001) begin
            errs++;
            $display("FAIL after_full_grant: got %b want 0001", wr_ready);
        end
        tick();
        wr_valid = '0;
        vecs++;
        if (count !== 4'd8 || full !== 1'b1) begin
            errs++;
            $display("FAIL refill: count=%0d f=%b want 8 1", count, full);
        end
        rd_req = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_ch = CW'(k % 4);
            vecs++;
            if (rd_valid !== 1'b1 || rd_ch !== exp_ch || rd_data !== 32'h100 + 32'(exp_ch)) begin
                errs++;
                $display("FAIL drain[%0d]: v=%b ch=%0d d=%h want 1 %0d %h",
                         k, rd_valid, rd_ch, rd_data, exp_ch, 32'h100 + 32'(exp_ch));
            end
        end
        rd_req = 1'b0;
        tick();
        vecs++;
        if (count !== 4'd0 || empty !== 1'b1 || rd_valid !== 1'b0) begin
            errs++;
            $display("FAIL drained: count=%0d e=%b v=%b want 0 1 0", count, empty, rd_valid);
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] q[$];
        logic [DW-1:0] exp_d;
        logic [DW-1:0] nd;
        wr_valid = 4'b1000;
        for (int i = 0; i < 2; i++) begin
            nd = 32'hBEEF_0000 + 32'(i);
            set_data(3, nd);
            q.push_back(nd);
            tick();
        end
        wr_valid = 4'b0010;
        rd_req = 1'b1;
        for (int k = 0; k < 20; k++) begin
            nd = 32'hC0DE_0000 + 32'(k);
            set_data(1, nd);
            exp_d = q.pop_front();
            q.push_back(nd);
            tick();
            vecs++;
            if (rd_valid !== 1'b1 || rd_data !== exp_d || count !== 4'd2) begin
                errs++;
                $display("FAIL wrap[%0d]: v=%b d=%h count=%0d want 1 %h 2",
                         k, rd_valid, rd_data, count, exp_d);
            end
        end
        wr_valid = '0;
        for (int k = 0; k < 2; k++) begin
            exp_d = q.pop_front();
            tick();
            vecs++;
            if (rd_valid !== 1'b1 || rd_data !== exp_d || rd_ch !== 2'd1) begin
                errs++;
                $display("FAIL wrap_tail[%0d]: v=%b d=%h ch=%0d want 1 %h 1",
                         k, rd_valid, rd_data, rd_ch, exp_d);
            end
        end
        rd_req = 1'b0;
        tick();
        vecs++;
        if (empty !== 1'b1 || underflow !== 1'b0) begin
            errs++;
            $display("FAIL wrap_end: e=%b uf=%b want 1 0", empty, underflow);
        end
    endtask

    task automatic test_underflow();
        rd_req = 1'b1;
        tick();
        vecs++;
        if (underflow !== 1'b1 || rd_valid !== 1'b0 || count !== 4'd0 ||
            rd_data !== 32'hC0DE_0013) begin
            errs++;
            $display("FAIL uf_set: uf=%b v=%b count=%0d d=%h want 1 0 0 c0de0013",
                     underflow, rd_valid, count, rd_data);
        end
        clr_err = 1'b1;
        tick();
        vecs++;
        if (underflow !== 1'b1) begin
            errs++;
            $display("FAIL uf_set_wins: got %b want 1", underflow);
        end
        rd_req = 1'b0;
        tick();
        clr_err = 1'b0;
        vecs++;
        if (underflow !== 1'b0) begin
            errs++;
            $display("FAIL uf_clear: got %b want 0", underflow);
        end
        tick();
        vecs++;
        if (underflow !== 1'b0 || empty !== 1'b1) begin
            errs++;
            $display("FAIL uf_idle: uf=%b e=%b want 0 1", underflow, empty);
        end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_single();
        test_async_reset();
        test_rr_and_full();
        test_wrap();
        test_underflow();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
